muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multi-cycle sequencer for the RV32M multiply/divide instructions. It replaces the combinational RV32M ALU path whenever the control unit asserts MDSel. The block latches operands, runs a 1-bit-per-cycle shift-add multiply or restoring divide, and applies RISC-V sign, divide-by-zero and overflow rules. While it works it holds the single-cycle core in place with a stall signal, and it presents the result to the write-back mux for exactly one cycle.

## Interface
- WIDTH, 32, operand and result width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; MDSel qualified by a valid RV32M instruction
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  WIDTH  rs1 value
- op_b  in  WIDTH  rs2 value
- stall  out  1  freeze PC and register-file write; combinational
- done  out  1  result valid this cycle; registered
- result  out  WIDTH  final value; held until next acceptance

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE**
  - When start=1, accept the request: latch funct3, op_a, op_b and the operand signs.
  - Load absolute values for the signed operands (MULH: both; MULHSU: op_a only; DIV/REM: both).
  - Clear the iteration counter and the accumulator.
- **IDLE special cases**, which go directly to DONE:
  - op_b==0 with DIV/DIVU: result all ones.
  - op_b==0 with REM/REMU: result op_a.
  - DIV with op_a=-2^(WIDTH-1) and op_b=-1: result op_a.
  - REM with the same overflow operands: result 0.
- **IDLE normal path**: otherwise go to CALC.
- **CALC**: WIDTH iterations, counter 0..WIDTH-1, then go to FIX.
  - Multiply: 2*WIDTH accumulator, shift-add on multiplier LSB, one bit per cycle.
  - Divide: restoring divide. Shift the remainder left by the next dividend bit, subtract the divisor if it does not underflow, and shift in the quotient bit.
- **FIX**: apply sign correction and result selection, then go to DONE.
  - Negate the product when the operand signs differ (MULH, MULHSU).
  - Negate the quotient when the signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL takes the low WIDTH bits. MULH/MULHSU/MULHU take the high WIDTH bits. DIV/DIVU take the quotient. REM/REMU take the remainder.
- **DONE**: done=1 for one cycle, then go to IDLE unconditionally.
- start is ignored outside IDLE. Operands are not re-sampled after acceptance.
- stall = (state==IDLE & start) | state==CALC | state==FIX.
- stall is 0 in DONE, so the core commits and advances on that edge. The next instruction's start is sampled in the following IDLE cycle.

## Timing
- Reset (async, rst_n=0): state IDLE, done 0, result 0, counter 0, accumulator 0. stall then follows start combinationally.
- Acceptance at edge 0.
  - Normal path: CALC occupies edges 1..WIDTH, FIX is at WIDTH+1, and done=1 in cycle WIDTH+2. Total latency is WIDTH+2 cycles (34 for WIDTH=32).
  - Special-case path: done=1 in the cycle after acceptance (latency 1).
- Back-to-back requests: the next start can be accepted in the IDLE cycle immediately after DONE. Minimum spacing is latency+1.
- Reset asserted mid-operation aborts immediately. No done pulse occurs, and result returns to 0.
- The counter is wide enough to hold WIDTH-1 and does not wrap.
- The CALC-to-FIX transition is taken on count==WIDTH-1.

## Configuration
- MD_FAST_MUL_EN
  - Defined: multiply ops (funct3[2]=0) use a single registered full-width signed/unsigned product. IDLE goes to FIX with the product latched, so latency is 2. Divide is unchanged.
  - Undefined: all ops are iterative as above.

## Structure
- Add to CPU_Control_Codes.vh:
  - MD_* funct3 encodings (MD_MUL … MD_REMU).
  - MDSEQ_* state encodings (2 bits).
- Sub-module muldiv_core holds the accumulator, remainder and quotient registers and one shift-add/subtract step per enable. The sequencer FSM, counter and sign/special-case logic stay in muldiv_sequencer.

## Test plan
- MUL 7×-3 (op_a=7, op_b=0xFFFFFFFD) -> result 0xFFFFFFEB; stall high for 33 cycles; done in cycle 34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with the same operands -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0. Each case has done one cycle after acceptance.
- rst_n pulsed low at CALC count 10:
  - Outputs go to reset values immediately, with no done pulse.
  - A new MUL 3×5 after release returns 15.
- start held high through DONE:
  - Exactly one done pulse per acceptance.
  - The second op (new operands) is accepted in the IDLE cycle after DONE.
  - With MD_FAST_MUL_EN defined, MUL latency is 2.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_pkg
// Shared encodings for the RV32M multi-cycle multiply/divide sequencer:
//   - MD_* funct3 encodings (MD_MUL .. MD_REMU)
//   - MDSEQ_* 2-bit FSM state encodings
//   - helpers that tell which RV32M ops treat op_a / op_b as signed
// -----------------------------------------------------------------------------
package muldiv_sequencer_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDSEQ_IDLE = 2'b00,
        MDSEQ_CALC = 2'b01,
        MDSEQ_FIX  = 2'b10,
        MDSEQ_DONE = 2'b11
    } mdseq_state_t;

    // op_a is signed for MULH, MULHSU, DIV and REM
    function automatic logic md_a_signed(input logic [2:0] f3);
        case (f3)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM: md_a_signed = 1'b1;
            default:                            md_a_signed = 1'b0;
        endcase
    endfunction

    // op_b is signed for MULH, DIV and REM
    function automatic logic md_b_signed(input logic [2:0] f3);
        case (f3)
            MD_MULH, MD_DIV, MD_REM: md_b_signed = 1'b1;
            default:                 md_b_signed = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_sequencer_core.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_core (module muldiv_core)
// Datapath for the iterative RV32M unit. Works on unsigned magnitudes; sign
// handling lives in the sequencer.
//   Multiply: r_acc += r_mcand when multiplier LSB is set, r_mcand << 1,
//             multiplier >> 1. After WIDTH steps r_acc is the 2*WIDTH product.
//   Divide:   restoring divide. r_acc = {remainder, quotient}; the dividend
//             bits are fed MSB first from r_mcand[WIDTH-1]; r_mplr is divisor.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_load       latch magnitudes and mode, clear accumulator
//   i_is_div     operation class at load (1 = divide)
//   i_step       perform one iteration
//   i_mag_a/b    operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   o_acc        accumulator: product, or {remainder, quotient}
// Build option: MD_FAST_MUL_EN loads the full product at i_load for multiplies.
// -----------------------------------------------------------------------------
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_is_div,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_mag_a,
    input  logic [WIDTH-1:0]     i_mag_b,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic               r_div_mode;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_sum;
`ifdef MD_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    // One-step arithmetic for both multiply and restoring divide
    always_comb begin
        w_trial = {r_acc[2*WIDTH-1:WIDTH], r_mcand[WIDTH-1]};
        w_ge    = (w_trial >= {1'b0, r_mplr});
        w_diff  = w_trial - {1'b0, r_mplr};
        w_sum   = r_acc + r_mcand;
`ifdef MD_FAST_MUL_EN
        w_fast_prod = {{WIDTH{1'b0}}, i_mag_a} * {{WIDTH{1'b0}}, i_mag_b};
`endif
    end

    // Datapath registers: load on acceptance, advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= {(2*WIDTH){1'b0}};
            r_mcand    <= {(2*WIDTH){1'b0}};
            r_mplr     <= {WIDTH{1'b0}};
            r_div_mode <= 1'b0;
        end else if (i_load) begin
`ifdef MD_FAST_MUL_EN
            r_acc      <= i_is_div ? {(2*WIDTH){1'b0}} : w_fast_prod;
`else
            r_acc      <= {(2*WIDTH){1'b0}};
`endif
            r_mcand    <= {{WIDTH{1'b0}}, i_mag_a};
            r_mplr     <= i_mag_b;
            r_div_mode <= i_is_div;
        end else if (i_step) begin
            if (r_div_mode) begin
                // keep the difference only when it did not underflow
                r_acc   <= {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                            r_acc[WIDTH-2:0], w_ge};
                r_mcand <= r_mcand << 1;
            end else begin
                r_acc   <= r_mplr[0] ? w_sum : r_acc;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
            end
        end else begin
            r_acc   <= r_acc;
            r_mcand <= r_mcand;
            r_mplr  <= r_mplr;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide sequencer. Accepts a request in IDLE,
// iterates WIDTH cycles in CALC, applies signs in FIX and pulses done in DONE.
// Divide-by-zero and signed overflow finish straight from IDLE.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request (MDSel qualified by a valid RV32M instruction)
//   funct3            RV32M operation
//   op_a, op_b        rs1 / rs2 values, sampled only at acceptance
//   stall             combinational hold for the PC and register-file write
//   done              registered one-cycle result-valid pulse
//   result            registered result, held until replaced
// Build option: MD_FAST_MUL_EN -- multiplies take IDLE -> FIX -> DONE.
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};

    mdseq_state_t r_state;
    mdseq_state_t w_state_nx;

    logic [CW-1:0]      r_count;
    logic [2:0]         r_f3;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special;
    logic               w_fast;
    logic [WIDTH-1:0]   w_special_res;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_res;

    // Request decode: operand magnitudes and the early-exit cases
    always_comb begin
        w_accept   = (r_state == MDSEQ_IDLE) & start;
        w_neg_a    = md_a_signed(funct3) & op_a[WIDTH-1];
        w_neg_b    = md_b_signed(funct3) & op_b[WIDTH-1];
        w_mag_a    = w_neg_a ? (ZERO_W - op_a) : op_a;
        w_mag_b    = w_neg_b ? (ZERO_W - op_b) : op_b;
        w_div_zero = funct3[2] & (op_b == ZERO_W);
        w_ovf      = ((funct3 == MD_DIV) | (funct3 == MD_REM)) &
                     (op_a == MIN_NEG) & (op_b == ONES_W);
        w_special  = w_div_zero | w_ovf;
`ifdef MD_FAST_MUL_EN
        w_fast     = ~funct3[2];
`else
        w_fast     = 1'b0;
`endif
        // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
        if (w_div_zero) begin
            w_special_res = funct3[1] ? op_a : ONES_W;
        end else if (w_ovf) begin
            w_special_res = funct3[1] ? ZERO_W : op_a;
        end else begin
            w_special_res = ZERO_W;
        end
    end

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_is_div (funct3[2]),
        .i_step   (r_state == MDSEQ_CALC),
        .i_mag_a  (w_mag_a),
        .i_mag_b  (w_mag_b),
        .o_acc    (w_acc)
    );

    // Sign correction and result selection used in FIX
    always_comb begin
        w_prod = (r_neg_a ^ r_neg_b) ? (ZERO_2W - w_acc) : w_acc;
        w_quot = (r_neg_a ^ r_neg_b) ? (ZERO_W - w_acc[WIDTH-1:0]) : w_acc[WIDTH-1:0];
        w_rem  = r_neg_a ? (ZERO_W - w_acc[2*WIDTH-1:WIDTH]) : w_acc[2*WIDTH-1:WIDTH];
        case (r_f3)
            MD_MUL:                       w_fix_res = w_prod[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:              w_fix_res = w_quot;
            MD_REM, MD_REMU:              w_fix_res = w_rem;
            default:                      w_fix_res = ZERO_W;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDSEQ_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next state and the combinational stall
    always_comb begin
        w_state_nx = r_state;
        stall      = 1'b0;
        case (r_state)
            MDSEQ_IDLE: begin
                if (start) begin
                    stall = 1'b1;
                    if (w_special) begin
                        w_state_nx = MDSEQ_DONE;
                    end else if (w_fast) begin
                        w_state_nx = MDSEQ_FIX;
                    end else begin
                        w_state_nx = MDSEQ_CALC;
                    end
                end else begin
                    w_state_nx = MDSEQ_IDLE;
                end
            end
            MDSEQ_CALC: begin
                stall = 1'b1;
                if (r_count == LAST_CNT) begin
                    w_state_nx = MDSEQ_FIX;
                end else begin
                    w_state_nx = MDSEQ_CALC;
                end
            end
            MDSEQ_FIX: begin
                stall      = 1'b1;
                w_state_nx = MDSEQ_DONE;
            end
            MDSEQ_DONE: begin
                w_state_nx = MDSEQ_IDLE;
            end
            default: begin
                w_state_nx = MDSEQ_IDLE;
            end
        endcase
    end

    // Iteration counter, request attributes, done pulse and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= {CW{1'b0}};
            r_f3     <= 3'b000;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= ZERO_W;
        end else begin
            r_done <= (w_state_nx == MDSEQ_DONE);
            if (w_accept) begin
                r_count <= {CW{1'b0}};
                r_f3    <= funct3;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
            end else if ((r_state == MDSEQ_CALC) && (r_count != LAST_CNT)) begin
                r_count <= r_count + CW'(1);
            end else begin
                r_count <= r_count;
            end
            if (w_accept && w_special) begin
                r_result <= w_special_res;
            end else if (r_state == MDSEQ_FIX) begin
                r_result <= w_fix_res;
            end else begin
                r_result <= r_result;
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Table-driven and random RV32M vectors with a result scoreboard, plus
// hand-written sequences for mid-operation reset and start held through DONE.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // RISC-V reference semantics using wide arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; ref_md = p[31:0]; end
            3'd1: begin p = sa * sb; ref_md = p[63:32]; end
            3'd2: begin p = sa * ub; ref_md = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; ref_md = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) ref_md = 32'hFFFF_FFFF;
                else begin p = sa / sb; ref_md = p[31:0]; end
            end
            3'd5: ref_md = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) ref_md = a;
                else begin p = sa % sb; ref_md = p[31:0]; end
            end
            default: ref_md = (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0)) return 1;
        if ((f3 == MD_DIV || f3 == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MD_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return 34;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    // Wait for done after an acceptance edge; returns cycles and stall count
    task automatic wait_done(output int n, output int stall_cnt, output bit seen);
        n = 0; stall_cnt = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (stall) stall_cnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n; int sc; bit seen; int lat;
        lat = ref_lat(f3, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1 chk("stall_req", {31'd0, stall}, 32'd1);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
        wait_done(n, sc, seen);
        if (!seen) begin
            n_chk++;
            $display("FAIL timeout: got no done expected done after %0d cycles", lat);
        end else begin
            chk("latency", n, lat);
            chk("stall_cycles", sc, lat - 1);
            chk("stall_in_done", {31'd0, stall}, 32'd0);
            @(negedge clk);
            chk("done_one_pulse", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int n; int sc; bit seen; int d0;
        logic [2:0] rf; logic [31:0] ra; logic [31:0] rb;

        vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{MD_DIVU,   32'd100,        32'd7,         32'd14};
        vecs[7]  = '{MD_REMU,   32'd100,        32'd7,         32'd2};
        vecs[8]  = '{MD_DIV,    32'd123,        32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{MD_REM,    32'd5,          32'd0,         32'd5};
        vecs[10] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{MD_DIVU,   32'd9,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{MD_REMU,   32'd9,          32'd0,         32'd9};

        rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        #1;
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        start = 1'b1;
        #1 chk("rst_stall_follows_start", {31'd0, stall}, 32'd1);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(rf, ra, rb, ref_md(rf, ra, rb));
        end

        // Mid-operation reset at CALC count 10
        run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        @(negedge clk);
        start = 1'b1; funct3 = MD_MUL; op_a = 32'd123; op_b = 32'd456;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_op(MD_MUL, 32'd3, 32'd5, 32'd15);

        // start held high through DONE: one pulse each, second op right after
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; funct3 = MD_DIVU; op_a = 32'd100; op_b = 32'd7;
        exp_q.push_back(32'd14);
        @(posedge clk); #1;
        funct3 = MD_MUL; op_a = 32'd3; op_b = 32'd5;
        exp_q.push_back(32'd15);
        wait_done(n, sc, seen);
        chk("held_lat1", n, 34);
        chk("held_stall_in_done", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("held_idle_done", {31'd0, done}, 32'd0);
        chk("held_idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 start = 1'b0;
        wait_done(n, sc, seen);
        chk("held_lat2", n, ref_lat(MD_MUL, 32'd3, 32'd5));
        repeat (5) @(negedge clk);
        chk("held_done_pulses", done_cnt - d0, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
